delay_scheduler: RTL
====================

Name: delay_scheduler

Overview:
- Shares one timed-delay counter among N_REQ requesters, e.g. game-phase timers and the LED/display hold timers.
- Requesters assert a level request with a delay length. The block picks one with round-robin arbitration and counts the delay on the shared counter, then pulses that requester's done line.
- Sits between the game-control FSMs and the shared timing resource, so each FSM does not need its own delay counter.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, delay length / counter width in bits
IDW, 2, width of active_id; must be >= clog2(N_REQ)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately
req  input  N_REQ  level request per requester
dur  input  N_REQ*WIDTH  delay length per requester; requester i uses bits [i*WIDTH +: WIDTH]
grant  output  N_REQ  one-hot; high while the requester owns the counter
done  output  N_REQ  one-cycle pulse when the owner's delay expires
busy  output  1  high when state != IDLE
active_id  output  IDW  index of the current owner; 0 when idle
remaining  output  WIDTH  current counter value; 0 when idle

Behaviour:
- States: IDLE, COUNT, DONE. All outputs are registered.
- Reset (reset=0):
  - state=IDLE, grant=0, done=0, busy=0, active_id=0, remaining=0.
  - Round-robin pointer rr_ptr=0.
  - Reset asserted mid-operation abandons the delay with no done pulse.
- IDLE:
  - If req != 0, choose the first set req bit, searching from rr_ptr upward with wrap (mod N_REQ); call it w.
  - On the next edge: grant[w]=1, active_id=w, remaining=dur[w] (sampled at that edge), rr_ptr=(w+1) mod N_REQ, state=COUNT.
  - If req == 0, stay in IDLE.
- COUNT:
  - If remaining==0, go to DONE.
  - Otherwise remaining -= 1 each cycle; it never wraps below 0.
  - dur changes and req deassertion by the owner are ignored while counting.
  - Requests from others are held pending (level); none are lost.
- DONE:
  - done[w]=1 for exactly one cycle; grant[w] stays high that cycle.
  - Next edge: state=IDLE, grant=0, done=0, active_id=0, remaining=0.
- Latency, with G = first cycle grant[w] is high:
  - req[w] seen high at edge k gives G = cycle after edge k.
  - done[w] is high in cycle G+d+1, where d = sampled dur[w].
  - grant[w] is high for d+2 cycles.
- dur=0: done in cycle G+1.
- dur=2^WIDTH-1: counts the full range with no overflow.
- Bubble: at least one IDLE cycle between consecutive grants. Back-to-back service of one requester takes d+3 cycles per delay.
- Owner still holding req in the IDLE cycle after DONE:
  - It is eligible again, but rr_ptr has already advanced past it.
  - Other pending requesters therefore win first.
- Simultaneous requests: only one grant at a time. grant is never multi-hot.

Optional Feature:
Macro: DELAY_SCHED_ABORT_EN
- Defined:
  - Adds input port "abort" (1 bit).
  - abort=1 in COUNT: next edge goes to IDLE, grant=0, remaining=0, no done pulse; rr_ptr keeps its advanced value.
  - abort in IDLE or DONE is ignored; in DONE the done pulse still completes.
- Undefined:
  - No abort port.
  - Every grant ends in exactly one done pulse unless reset is asserted.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req=4'b1111 → grant=0, busy=0, remaining=0. After release the first grant is requester 0.
- Single delay: N_REQ=4, WIDTH=8, req[2]=1, dur[2]=5 → grant=4'b0100 from cycle G for 7 cycles; remaining steps 5,4,3,2,1,0; done[2] pulses once at G+6; busy low at G+7.
- Zero delay: req[1]=1, dur[1]=0 → done[1] at G+1; grant high 2 cycles.
- Round-robin: req=4'b1011 held high, all dur=1 → grant order 0,1,3,0,1,3. Each grant lasts 3 cycles with 1 IDLE bubble between grants.
- Mid-operation reset: dur[0]=200; pull reset low at remaining=100 → all outputs 0 immediately (asynchronously), no done pulse. After release rr_ptr=0.
- Abort (with DELAY_SCHED_ABORT_EN): dur[3]=50; abort at remaining=20 → grant low next cycle, done never pulses. Pending req[0] is granted after one IDLE cycle. Without the macro, the same bench minus abort sees done[3] at G+51.

Source files
------------

// File: rtl/delay_scheduler_if.sv
// ---------------------------------------------------------------------------
// delay_scheduler_if
//
// Purpose:
//   Groups the requester-facing signals of delay_scheduler into a single
//   bundle. The requesters (game-control FSMs) sit on the master side and
//   the scheduler sits on the slave side.
//
// Signals:
//   req        N_REQ         level request per requester
//   dur        N_REQ*WIDTH   delay length, requester i at [i*WIDTH +: WIDTH]
//   grant      N_REQ         one-hot, high while a requester owns the counter
//   done       N_REQ         one-cycle pulse when the owner's delay expires
//   busy       1             scheduler is not idle
//   active_id  IDW           index of the current owner, 0 when idle
//   remaining  WIDTH         current counter value, 0 when idle
//   abort      1             only present when DELAY_SCHED_ABORT_EN is defined;
//                            cancels the delay currently being counted
//
// Modports:
//   master  requester side (drives req/dur/abort)
//   slave   scheduler side (drives grant/done/busy/active_id/remaining)
// ---------------------------------------------------------------------------
interface delay_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] dur;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [IDW-1:0]         active_id;
  logic [WIDTH-1:0]       remaining;
`ifdef DELAY_SCHED_ABORT_EN
  logic                   abort;
`endif

  modport master (
    output req,
    output dur,
    input  grant,
    input  done,
    input  busy,
    input  active_id,
    input  remaining
`ifdef DELAY_SCHED_ABORT_EN
    ,
    output abort
`endif
  );

  modport slave (
    input  req,
    input  dur,
    output grant,
    output done,
    output busy,
    output active_id,
    output remaining
`ifdef DELAY_SCHED_ABORT_EN
    ,
    input  abort
`endif
  );

endinterface

// File: rtl/delay_scheduler.sv
// ---------------------------------------------------------------------------
// delay_scheduler
//
// Purpose:
//   Shares one timed-delay counter among N_REQ requesters (game-phase
//   timers, LED/display hold timers, ...). A requester raises its level
//   request together with a delay length. The scheduler grants one requester
//   at a time, using round-robin arbitration, and loads the shared counter
//   with that requester's delay. It counts the delay down to zero and then
//   pulses the owner's done line for one cycle.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   WIDTH  delay length / counter width in bits
//   IDW    width of active_id, must be >= clog2(N_REQ)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    delay_scheduler_if.slave (req, dur, grant, done, busy,
//          active_id, remaining, and optionally abort)
//
// Configuration:
//   DELAY_SCHED_ABORT_EN  when defined, bus.abort cancels a delay that is
//                         being counted. The owner gets no done pulse.
//
// Timing (G = first cycle grant is high, d = sampled delay):
//   grant is high for d+2 cycles and done pulses in cycle G+d+1. There is
//   always at least one idle cycle between two grants.
// ---------------------------------------------------------------------------
module delay_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               reset,
  delay_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [N_REQ-1:0]  grant_q;
  logic [N_REQ-1:0]  done_q;
  logic              busy_q;
  logic [IDW-1:0]    active_id_q;
  logic [WIDTH-1:0]  remaining_q;
  logic [IDW-1:0]    rr_ptr;

  logic              win_found;
  logic [IDW-1:0]    win_id;
  logic [N_REQ-1:0]  win_onehot;
  logic [WIDTH-1:0]  win_dur;
  logic [IDW-1:0]    next_ptr;

  logic              hi_found;
  logic [IDW-1:0]    hi_id;
  logic              lo_found;
  logic [IDW-1:0]    lo_id;

  logic              abort_req;

  // Round-robin pick. The search runs in two passes. The "hi" pass looks only
  // at requesters at or above rr_ptr. The "lo" pass looks at all of them, so
  // it covers the wrap-around case. Both passes scan downward so that the
  // lowest matching index wins. The hi result takes priority, which gives a
  // search that starts at rr_ptr and wraps modulo N_REQ.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
        if (IDW'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    win_found = hi_found | lo_found;
    win_id    = hi_found ? hi_id : lo_id;
  end

  // Decode the winner into a one-hot grant vector. Also select its delay
  // slice here, so the sequential block only deals with plain vectors.
  always_comb begin
    win_onehot = '0;
    win_dur    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == win_id) begin
        win_onehot[i] = 1'b1;
        win_dur       = bus.dur[i*WIDTH +: WIDTH];
      end
    end
  end

  // The pointer moves to the slot just past the winner. A requester that is
  // still holding its request after being served therefore goes behind
  // every other pending requester.
  always_comb begin
    next_ptr = '0;
    if (win_id != IDW'(N_REQ - 1)) begin
      next_ptr = win_id + 1'b1;
    end
  end

`ifdef DELAY_SCHED_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Main scheduler FSM. All outputs are registered here.
  // IDLE:  wait for any request, then latch the winner and its delay.
  // COUNT: decrement until zero. The owner's req/dur are not looked at, so
  //        dropping req or changing dur mid-delay has no effect.
  // DONE:  a single cycle in which done is pulsed while grant is still held.
  // An asynchronous reset drops everything with no done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      active_id_q <= '0;
      remaining_q <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= '0;
          if (win_found) begin
            state       <= COUNT;
            grant_q     <= win_onehot;
            busy_q      <= 1'b1;
            active_id_q <= win_id;
            remaining_q <= win_dur;
            rr_ptr      <= next_ptr;
          end
        end

        COUNT: begin
          if (abort_req) begin
            state       <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            active_id_q <= '0;
            remaining_q <= '0;
          end else if (remaining_q == '0) begin
            state  <= DONE;
            done_q <= grant_q;
          end else begin
            remaining_q <= remaining_q - 1'b1;
          end
        end

        DONE: begin
          state       <= IDLE;
          grant_q     <= '0;
          done_q      <= '0;
          busy_q      <= 1'b0;
          active_id_q <= '0;
          remaining_q <= '0;
        end

        default: begin
          state       <= IDLE;
          grant_q     <= '0;
          done_q      <= '0;
          busy_q      <= 1'b0;
          active_id_q <= '0;
          remaining_q <= '0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = active_id_q;
  assign bus.remaining = remaining_q;

endmodule
